// File: rtl/mips_pipe_defs.sv
// mips_pipe_defs: shared field-width defaults and ID/EX occupancy state encoding.
// No ports; imported by the ID/EX buffer and its payload register.
package mips_pipe_defs;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;
endpackage

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: six-field ID/EX payload register with synchronous clear and load.
// Ports: clk; clear (zeroes all fields, wins over load); load (captures d_*);
//        d_adder/d_rd1/d_rd2/d_sext/d_ins_a/d_ins_b in; q_* registered copies out.
module pipe_payload_reg
    import mips_pipe_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d_adder,
    input  logic [DATA_W-1:0] d_rd1,
    input  logic [DATA_W-1:0] d_rd2,
    input  logic [DATA_W-1:0] d_sext,
    input  logic [REG_W-1:0]  d_ins_a,
    input  logic [REG_W-1:0]  d_ins_b,
    output logic [DATA_W-1:0] q_adder,
    output logic [DATA_W-1:0] q_rd1,
    output logic [DATA_W-1:0] q_rd2,
    output logic [DATA_W-1:0] q_sext,
    output logic [REG_W-1:0]  q_ins_a,
    output logic [REG_W-1:0]  q_ins_b
);
    always_ff @(posedge clk) begin
        if (clear) begin
            q_adder <= '0;
            q_rd1   <= '0;
            q_rd2   <= '0;
            q_sext  <= '0;
            q_ins_a <= '0;
            q_ins_b <= '0;
        end else if (load) begin
            q_adder <= d_adder;
            q_rd1   <= d_rd1;
            q_rd2   <= d_rd2;
            q_sext  <= d_sext;
            q_ins_a <= d_ins_a;
            q_ins_b <= d_ins_b;
        end
    end
endmodule

// File: rtl/buffer_id_ex_hs.sv
// buffer_id_ex_hs: valid/ready ID/EX pipeline register with optional skid entry and flush.
// Ports: clk, rst_n (sync, active-low), flush (drop all entries);
//        in_valid/in_ready + inAdder/inRD1/inRD2/inSignExt/inInsA/inInsB from ID;
//        out_valid/out_ready + outAdder/outRD1/outRD2/outSignExt/outInsA/outInsB to EX;
//        occupancy = number of held entries (0..2).
module buffer_id_ex_hs
    import mips_pipe_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] inAdder,
    input  logic [DATA_W-1:0] inRD1,
    input  logic [DATA_W-1:0] inRD2,
    input  logic [DATA_W-1:0] inSignExt,
    input  logic [REG_W-1:0]  inInsA,
    input  logic [REG_W-1:0]  inInsB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] outAdder,
    output logic [DATA_W-1:0] outRD1,
    output logic [DATA_W-1:0] outRD2,
    output logic [DATA_W-1:0] outSignExt,
    output logic [REG_W-1:0]  outInsA,
    output logic [REG_W-1:0]  outInsB,
    output logic [1:0]        occupancy
);
    state_t state, state_nx;
    logic ready_q;
    logic in_xfer, out_xfer, clr, main_load, main_from_skid, skid_load;
    logic [DATA_W-1:0] s_adder, s_rd1, s_rd2, s_sext;
    logic [REG_W-1:0]  s_ins_a, s_ins_b;

    // Gating with rst_n keeps in_ready low during reset while the flop itself
    // resets high so the stage is ready the first cycle after release.
    assign in_ready       = rst_n && (SKID ? ready_q : (!out_valid || out_ready));
    assign out_valid      = state != EMPTY;
    assign occupancy      = state;
    assign in_xfer        = in_valid && in_ready;
    assign out_xfer       = out_valid && out_ready;
    assign clr            = !rst_n || flush;
    assign main_from_skid = state == TWO && out_xfer;
    assign main_load      = (in_xfer && (state == EMPTY || out_xfer)) || main_from_skid;
    assign skid_load      = SKID && state == ONE && in_xfer && !out_xfer;

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (in_xfer) state_nx = ONE;
            ONE: begin
                if (in_xfer && !out_xfer) state_nx = SKID ? TWO : ONE;
                else if (!in_xfer && out_xfer) state_nx = EMPTY;
            end
            TWO: if (out_xfer) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
        if (flush) state_nx = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            ready_q <= state_nx != TWO;
        end
    end

    pipe_payload_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_main (
        .clk    (clk),
        .clear  (clr),
        .load   (main_load),
        .d_adder(main_from_skid ? s_adder : inAdder),
        .d_rd1  (main_from_skid ? s_rd1   : inRD1),
        .d_rd2  (main_from_skid ? s_rd2   : inRD2),
        .d_sext (main_from_skid ? s_sext  : inSignExt),
        .d_ins_a(main_from_skid ? s_ins_a : inInsA),
        .d_ins_b(main_from_skid ? s_ins_b : inInsB),
        .q_adder(outAdder),
        .q_rd1  (outRD1),
        .q_rd2  (outRD2),
        .q_sext (outSignExt),
        .q_ins_a(outInsA),
        .q_ins_b(outInsB)
    );

    generate
        if (SKID) begin : g_skid
            // Skid empties when its beat moves into main.
            pipe_payload_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_skid (
                .clk    (clk),
                .clear  (clr || main_from_skid),
                .load   (skid_load),
                .d_adder(inAdder),
                .d_rd1  (inRD1),
                .d_rd2  (inRD2),
                .d_sext (inSignExt),
                .d_ins_a(inInsA),
                .d_ins_b(inInsB),
                .q_adder(s_adder),
                .q_rd1  (s_rd1),
                .q_rd2  (s_rd2),
                .q_sext (s_sext),
                .q_ins_a(s_ins_a),
                .q_ins_b(s_ins_b)
            );
        end else begin : g_noskid
            assign s_adder = '0;
            assign s_rd1   = '0;
            assign s_rd2   = '0;
            assign s_sext  = '0;
            assign s_ins_a = '0;
            assign s_ins_b = '0;
        end
    endgenerate
endmodule

// File: tb/tb_buffer_id_ex_hs.sv
// tb_buffer_id_ex_hs: checks SKID=1 and SKID=0 builds against a FIFO-queue reference model.
// Ports: none.
module tb_buffer_id_ex_hs;
    typedef struct packed {
        logic [31:0] adder;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  ia;
        logic [4:0]  ib;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    beat_t din = '0;

    logic        rdy[2];
    logic        vld[2];
    logic [1:0]  occ[2];
    logic [31:0] o_adder[2];
    logic [31:0] o_rd1[2];
    logic [31:0] o_rd2[2];
    logic [31:0] o_sext[2];
    logic [4:0]  o_ia[2];
    logic [4:0]  o_ib[2];

    // Reference: each build is a FIFO of accepted beats with capacity 2 (skid) or 1.
    beat_t mq[2][$];
    bit    zero_out[2];
    int    passed = 0;
    int    total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        buffer_id_ex_hs #(.DATA_W(32), .REG_W(5), .SKID(g == 1)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (rdy[g]),
            .inAdder   (din.adder),
            .inRD1     (din.rd1),
            .inRD2     (din.rd2),
            .inSignExt (din.sext),
            .inInsA    (din.ia),
            .inInsB    (din.ib),
            .out_valid (vld[g]),
            .out_ready (out_ready),
            .outAdder  (o_adder[g]),
            .outRD1    (o_rd1[g]),
            .outRD2    (o_rd2[g]),
            .outSignExt(o_sext[g]),
            .outInsA   (o_ia[g]),
            .outInsB   (o_ib[g]),
            .occupancy (occ[g])
        );
    end

    task automatic check(input string tag, input int k, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s skid=%0d observed=%h expected=%h", tag, k, obs, exp);
    endtask

    function automatic bit exp_ready(input int k);
        if (!rst_n) return 1'b0;
        return (k == 1) ? (mq[k].size() < 2) : (mq[k].size() == 0 || out_ready);
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.adder = $urandom;
        b.rd1   = $urandom;
        b.rd2   = $urandom;
        b.sext  = $urandom;
        b.ia    = 5'($urandom);
        b.ib    = 5'($urandom);
        return b;
    endfunction

    function automatic beat_t mk(input logic [31:0] rd1, input logic [31:0] sext, input logic [4:0] ia);
        beat_t b;
        b = rnd_beat();
        b.rd1  = rd1;
        b.sext = sext;
        b.ia   = ia;
        return b;
    endfunction

    task automatic step(input logic rs, input logic fl, input logic iv, input logic ordy, input beat_t b);
        bit er[2];
        beat_t obs;
        rst_n = rs;
        flush = fl;
        in_valid = iv;
        out_ready = ordy;
        din = b;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            er[k] = exp_ready(k);
            obs = {o_adder[k], o_rd1[k], o_rd2[k], o_sext[k], o_ia[k], o_ib[k]};
            check("in_ready", k, 160'(rdy[k]), 160'(er[k]));
            check("out_valid", k, 160'(vld[k]), 160'(mq[k].size() > 0));
            check("occupancy", k, 160'(occ[k]), 160'(mq[k].size()));
            if (mq[k].size() > 0) check("payload", k, 160'(obs), 160'(mq[k][0]));
            else if (zero_out[k]) check("payload_zero", k, 160'(obs), 160'(0));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || flush) begin
                mq[k].delete();
                zero_out[k] = 1'b1;
            end else begin
                if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
                if (in_valid && er[k]) begin
                    mq[k].push_back(din);
                    zero_out[k] = 1'b0;
                end
            end
        end
        #1;
    endtask

    initial begin
        zero_out[0] = 1'b1;
        zero_out[1] = 1'b1;
        @(posedge clk);
        #1;
        // Reset held with in_valid high, then release.
        step(0, 0, 1, 1, rnd_beat());
        step(0, 0, 1, 1, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        // Streaming with EX always ready.
        step(1, 0, 1, 1, mk(32'h11, 32'h0, 5'd1));
        step(1, 0, 1, 1, mk(32'h22, 32'h0, 5'd2));
        step(1, 0, 1, 1, mk(32'h33, 32'h0, 5'd3));
        step(1, 0, 0, 1, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        // Stall: second beat lands in the skid entry.
        step(1, 0, 1, 1, mk(32'h11, 32'h0, 5'd4));
        step(1, 0, 1, 0, mk(32'h22, 32'h0, 5'd5));
        step(1, 0, 1, 0, mk(32'h99, 32'h0, 5'd6));
        step(1, 0, 0, 1, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        // Flush while full, with a beat offered the same cycle.
        step(1, 0, 1, 0, mk(32'h55, 32'h0, 5'd7));
        step(1, 0, 1, 0, mk(32'h66, 32'h0, 5'd8));
        step(1, 1, 1, 1, mk(32'h44, 32'h0, 5'd9));
        step(1, 0, 0, 1, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        // Held negative immediate under back-pressure.
        step(1, 0, 1, 0, mk(32'h77, 32'hFFFF_FFF0, 5'd10));
        step(1, 0, 0, 0, rnd_beat());
        step(1, 0, 0, 0, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        // Reset during a full stall, then a fresh beat.
        step(1, 0, 1, 0, mk(32'h88, 32'h0, 5'd11));
        step(1, 0, 1, 0, mk(32'h89, 32'h0, 5'd12));
        step(0, 0, 1, 0, rnd_beat());
        step(1, 0, 1, 1, mk(32'hAA, 32'h0, 5'd31));
        step(1, 0, 0, 1, rnd_beat());
        step(1, 0, 0, 1, rnd_beat());
        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++)
            step($urandom_range(39) != 0, $urandom_range(19) == 0, 1'($urandom), $urandom_range(3) != 0, rnd_beat());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
